reg_axil_master_bridge: RTL and testbench

- AXI4-Lite slave that converts PS-side bus accesses into the single-cycle register strobe interface consumed by the TLK2711 register manager: wen/waddr/wdata and ren/raddr, plus a fixed-latency rdata return.
- It is the initiator end of that interface. It sits between the PS AXI port and the register manager, in the PS clock domain.
- It serialises reads and writes, allowing one outstanding transaction at a time.

---
 rtl/reg_axil_master_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_reg_axil_master_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_axil_master_bridge.sv
// reg_axil_master_bridge
//
// AXI4-Lite slave that turns PS-side bus accesses into the single-cycle
// strobe interface of the TLK2711 register manager. Only one transaction is
// in flight at a time. When AW/W and AR arrive together, the write goes first.
//
// Ports
//   clk, rst_n            PS clock, asynchronous active-low reset
//   s_axil_aw*            write address channel (16-bit byte address)
//   s_axil_w*             write data channel (64-bit data, 8 byte strobes)
//   s_axil_b*             write response channel
//   s_axil_ar*            read address channel
//   s_axil_r*             read data channel
//   o_reg_wen/waddr/wdata one-cycle write strobe with address and data
//   o_reg_ren/raddr       one-cycle read strobe with address
//   i_reg_rdata           read data, valid RD_LATENCY cycles after o_reg_ren
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | collecting AW/W, or accepting AR when no write is pending
// WR_ISSUE | o_reg_wen is high in this cycle (unless the write is rejected)
// WR_RESP  | bvalid is high, waiting for bready
// RD_ISSUE | o_reg_ren is high in this cycle (unless the read is rejected)
// RD_WAIT  | counting down the register manager's read latency
// RD_RESP  | rvalid is high, waiting for rready

module reg_axil_master_bridge #(
    parameter int RD_LATENCY = 6,
    parameter int ADDR_LSB   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [63:0] s_axil_wdata,
    input  logic [7:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [15:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [63:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic        o_reg_wen,
    output logic [15:0] o_reg_waddr,
    output logic [63:0] o_reg_wdata,
    output logic        o_reg_ren,
    output logic [15:0] o_reg_raddr,
    input  logic [63:0] i_reg_rdata
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_ISSUE = 3'd1;
    localparam logic [2:0] S_WR_RESP  = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_RESP  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]  state;
    logic        run;
    logic        aw_held;
    logic        w_held;
    logic [15:0] aw_addr;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [15:0] ar_addr;
    logic [3:0]  cnt;

    logic        idle;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        wr_misaligned;
    logic        wr_zero_strb;
    logic        rd_misaligned;
    logic        ar_in_misaligned;

    // run keeps every ready low while reset is asserted, even though the FSM
    // already sits in IDLE.
    assign idle = run && (state == S_IDLE);

    assign s_axil_awready = idle && !aw_held;
    assign s_axil_wready  = idle && !w_held;
    // AR is also refused when AW or W arrives in the same cycle, so that a
    // write that is only half collected cannot be overtaken by a read.
    assign s_axil_arready = idle && !aw_held && !w_held
                            && !s_axil_awvalid && !s_axil_wvalid;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid  && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    assign wr_misaligned    = |aw_addr[ADDR_LSB-1:0];
    assign wr_zero_strb     = ~|w_strb;
    assign rd_misaligned    = |ar_addr[ADDR_LSB-1:0];
    assign ar_in_misaligned = |s_axil_araddr[ADDR_LSB-1:0];

    // Strobes are launched on the transition into WR_ISSUE/RD_ISSUE.
    // This makes o_reg_wen/o_reg_ren registered outputs that are high for
    // exactly the ISSUE cycle. The read counter is loaded during RD_ISSUE.
    // As a result, i_reg_rdata is sampled RD_LATENCY cycles after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            run           <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            ar_addr       <= '0;
            cnt           <= '0;
            s_axil_bresp  <= RESP_OKAY;
            s_axil_bvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rvalid <= 1'b0;
            o_reg_wen     <= 1'b0;
            o_reg_waddr   <= '0;
            o_reg_wdata   <= '0;
            o_reg_ren     <= 1'b0;
            o_reg_raddr   <= '0;
        end else begin
            run       <= 1'b1;
            o_reg_wen <= 1'b0;
            o_reg_ren <= 1'b0;

            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end

            case (state)
                S_IDLE: begin
                    if (aw_held && w_held) begin
                        // The register manager has no byte enables. Any
                        // non-zero strobe therefore writes the whole word.
                        if (!wr_misaligned && !wr_zero_strb) begin
                            o_reg_wen   <= 1'b1;
                            o_reg_waddr <= aw_addr;
                            o_reg_wdata <= w_data;
                        end
                        state <= S_WR_ISSUE;
                    end else if (ar_hs) begin
                        ar_addr <= s_axil_araddr;
                        if (!ar_in_misaligned) begin
                            o_reg_ren   <= 1'b1;
                            o_reg_raddr <= s_axil_araddr;
                        end
                        state <= S_RD_ISSUE;
                    end
                end

                S_WR_ISSUE: begin
                    s_axil_bvalid <= 1'b1;
                    s_axil_bresp  <= wr_misaligned ? RESP_SLVERR : RESP_OKAY;
                    state         <= S_WR_RESP;
                end

                S_WR_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                S_RD_ISSUE: begin
                    if (rd_misaligned) begin
                        s_axil_rdata  <= '0;
                        s_axil_rresp  <= RESP_SLVERR;
                        s_axil_rvalid <= 1'b1;
                        state         <= S_RD_RESP;
                    end else begin
                        cnt   <= 4'(RD_LATENCY - 1);
                        state <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        s_axil_rdata  <= i_reg_rdata;
                        s_axil_rresp  <= RESP_OKAY;
                        s_axil_rvalid <= 1'b1;
                        state         <= S_RD_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_RD_RESP: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_axil_master_bridge.sv
module tb_reg_axil_master_bridge;

    localparam int RD_LAT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [63:0] s_axil_wdata = '0;
    logic [7:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b1;
    logic [15:0] s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [63:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b1;
    logic        o_reg_wen;
    logic [15:0] o_reg_waddr;
    logic [63:0] o_reg_wdata;
    logic        o_reg_ren;
    logic [15:0] o_reg_raddr;
    logic [63:0] i_reg_rdata = 64'hDEAD_BEEF_DEAD_BEEF;

    reg_axil_master_bridge #(.RD_LATENCY(RD_LAT), .ADDR_LSB(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
        .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_wen = 0;
    int n_ren = 0;

    logic [79:0] wq[$];     // {waddr, wdata}
    logic [1:0]  bq[$];
    logic [65:0] rq[$];     // {rresp, rdata}
    logic [15:0] renq[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register manager model: data is valid only in the RD_LAT-th cycle after the strobe.
    function automatic logic [63:0] mem_data(input logic [15:0] a);
        case (a)
            16'h0040: return 64'h0123_4567_89AB_CDEF;
            16'h0050: return 64'hA000_0000_0000_003F;
            16'h0060: return 64'h1234_5678_9ABC_DEF0;
            default:  return 64'h5555_AAAA_5555_AAAA;
        endcase
    endfunction

    initial begin
        logic [15:0] a;
        forever begin
            @(negedge clk);
            if (rst_n && o_reg_ren) begin
                a = o_reg_raddr;
                repeat (RD_LAT) @(posedge clk);
                #1 i_reg_rdata = mem_data(a);
                @(posedge clk);
                #1 i_reg_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [79:0] ew;
        logic [65:0] er;
        logic [15:0] ea;
        logic [1:0]  eb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_reg_wen) begin
                    n_wen++;
                    if (wq.size() == 0) chk("unexpected_wen", {o_reg_waddr, o_reg_wdata}, 80'h0);
                    else begin
                        ew = wq.pop_front();
                        chk("wen_addr_data", {o_reg_waddr, o_reg_wdata}, ew);
                    end
                end
                if (o_reg_ren) begin
                    n_ren++;
                    if (renq.size() == 0) chk("unexpected_ren", {64'h0, o_reg_raddr}, 80'h0);
                    else begin
                        ea = renq.pop_front();
                        chk("ren_addr", {64'h0, o_reg_raddr}, {64'h0, ea});
                    end
                end
                if (s_axil_bvalid && s_axil_bready) begin
                    if (bq.size() == 0) chk("unexpected_b", 80'h1, 80'h0);
                    else begin
                        eb = bq.pop_front();
                        chk("bresp", {78'h0, s_axil_bresp}, {78'h0, eb});
                    end
                end
                if (s_axil_rvalid && s_axil_rready) begin
                    if (rq.size() == 0) chk("unexpected_r", 80'h1, 80'h0);
                    else begin
                        er = rq.pop_front();
                        chk("rresp_rdata", {14'h0, s_axil_rresp, s_axil_rdata}, {14'h0, er});
                    end
                end
            end
        end
    end

    task automatic send_aw(input logic [15:0] a);
        logic fire;
        int i;
        @(posedge clk); #1;
        s_axil_awaddr = a; s_axil_awvalid = 1'b1;
        fire = 1'b0;
        for (i = 0; i < 100 && !fire; i++) begin
            @(negedge clk); fire = s_axil_awready;
            @(posedge clk); #1;
        end
        s_axil_awvalid = 1'b0;
        chk("aw_handshake_timeout", {79'h0, fire}, 80'h1);
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        logic fire;
        int i;
        @(posedge clk); #1;
        s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
        fire = 1'b0;
        for (i = 0; i < 100 && !fire; i++) begin
            @(negedge clk); fire = s_axil_wready;
            @(posedge clk); #1;
        end
        s_axil_wvalid = 1'b0;
        chk("w_handshake_timeout", {79'h0, fire}, 80'h1);
    endtask

    task automatic send_ar(input logic [15:0] a);
        logic fire;
        int i;
        @(posedge clk); #1;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        fire = 1'b0;
        for (i = 0; i < 100 && !fire; i++) begin
            @(negedge clk); fire = s_axil_arready;
            @(posedge clk); #1;
        end
        s_axil_arvalid = 1'b0;
        chk("ar_handshake_timeout", {79'h0, fire}, 80'h1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200 && (wq.size() + bq.size() + rq.size() + renq.size()) != 0; i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        chk("drain_timeout", 80'(wq.size() + bq.size() + rq.size() + renq.size()), 80'h0);
    endtask

    initial begin
        int bad;
        int i;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_readys", {77'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 80'h0);
        chk("rst_valids", {78'h0, s_axil_bvalid, s_axil_rvalid}, 80'h0);
        chk("rst_strobes", {78'h0, o_reg_wen, o_reg_ren}, 80'h0);
        chk("rst_resps", {76'h0, s_axil_bresp, s_axil_rresp}, 80'h0);
        chk("rst_reg_addrs", {48'h0, o_reg_waddr, o_reg_raddr}, 80'h0);
        chk("rst_wdata", {16'h0, o_reg_wdata}, 80'h0);
        chk("rst_rdata", {16'h0, s_axil_rdata}, 80'h0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("awready_after_rst", {79'h0, s_axil_awready}, 80'h1);

        // Aligned write with AW and W in the same cycle
        wq.push_back({16'h0020, 64'h0000_0000_8000_0000});
        bq.push_back(2'b00);
        fork
            send_aw(16'h0020);
            send_w(64'h0000_0000_8000_0000, 8'hFF);
        join
        drain();

        // W before AW. A partial strobe still writes the full word.
        wq.push_back({16'h0008, 64'hFFFF_FFFF_0000_1111});
        bq.push_back(2'b00);
        s_axil_wdata = 64'hFFFF_FFFF_0000_1111; s_axil_wstrb = 8'h0F;
        bad = 0;
        send_w(64'hFFFF_FFFF_0000_1111, 8'h0F);
        for (i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_axil_arready) bad++;
        end
        chk("arready_low_w_held", 80'(bad), 80'h0);
        send_aw(16'h0008);
        drain();

        // Aligned read; data is present only in the 6th cycle after o_reg_ren
        renq.push_back(16'h0050);
        rq.push_back({2'b00, 64'hA000_0000_0000_003F});
        send_ar(16'h0050);
        drain();

        // Write response backpressure blocks a following read
        s_axil_bready = 1'b0;
        wq.push_back({16'h0030, 64'h0000_00C0_FFEE_0030});
        bq.push_back(2'b00);
        fork
            send_aw(16'h0030);
            send_w(64'h0000_00C0_FFEE_0030, 8'hFF);
        join
        for (i = 0; i < 50 && !s_axil_bvalid; i++) @(negedge clk);
        chk("bvalid_seen", {79'h0, s_axil_bvalid}, 80'h1);
        @(posedge clk); #1;
        s_axil_araddr = 16'h0040; s_axil_arvalid = 1'b1;
        bad = 0;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!s_axil_bvalid || s_axil_arready) bad++;
        end
        chk("b_hold_ar_blocked", 80'(bad), 80'h0);
        renq.push_back(16'h0040);
        rq.push_back({2'b00, 64'h0123_4567_89AB_CDEF});
        @(posedge clk); #1 s_axil_bready = 1'b1;
        send_ar(16'h0040);
        drain();

        // Misaligned write
        bq.push_back(2'b10);
        fork
            send_aw(16'h0023);
            send_w(64'h1111_2222_3333_4444, 8'hFF);
        join
        drain();

        // Misaligned read
        rq.push_back({2'b10, 64'h0});
        send_ar(16'h0041);
        drain();

        // Zero-strobe write
        bq.push_back(2'b00);
        fork
            send_aw(16'h0010);
            send_w(64'h9999_8888_7777_6666, 8'h00);
        join
        drain();

        // Reset during RD_WAIT aborts the read with no response
        renq.push_back(16'h0070);
        send_ar(16'h0070);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {77'h0, s_axil_rvalid, o_reg_ren, s_axil_arready}, 80'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        for (i = 0; i < 15; i++) begin
            @(negedge clk);
            if (s_axil_rvalid) bad++;
        end
        chk("rvalid_after_abort", 80'(bad), 80'h0);
        renq.push_back(16'h0060);
        rq.push_back({2'b00, 64'h1234_5678_9ABC_DEF0});
        send_ar(16'h0060);
        drain();

        chk("total_wen", 80'(n_wen), 80'd3);
        chk("total_ren", 80'(n_ren), 80'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
